// File: rtl/dtw_sched_pkg.sv
// rtl/dtw_sched_pkg.sv - shared types, constants and round-robin helpers for the DTW job scheduler
//
// Purpose: per-core state encoding, result/job-length widths and the
// round-robin picker used by both the dispatch and the output arbiter.
// Ports: none (package).
package dtw_sched_pkg;

  typedef enum logic [1:0] {
    CORE_FREE  = 2'd0,
    CORE_LOAD  = 2'd1,
    CORE_WAIT  = 2'd2,
    CORE_DRAIN = 2'd3
  } core_state_e;

  localparam int RESULT_WORDS = 3;
  // ref_len + 1 + SQG_SIZE can exceed 32 bits when ref_len is near its max
  localparam int JOB_W        = 33;
  localparam int MAX_CORES    = 8;

  // Returns {found, index}: first requester at or after 'start', wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [MAX_CORES-1:0] req,
                                         input logic [2:0] start,
                                         input int n);
    logic [3:0] res;
    int idx;
    res = '0;
    // Scan from the far end so the closest candidate to 'start' wins.
    for (int k = MAX_CORES - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(start) + k) % n;
        if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/dtw_sched_result_buf.sv
// rtl/dtw_sched_result_buf.sv - three-word capture buffer for one core's result
//
// Purpose: collects qid, position, minval from one core and holds them until
// the output arbiter has copied all three words out.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_en_i, wr_data_i  result write from the core
//   clr_i               empty the buffer (after the third word is taken)
//   rd_idx_i            word select for the drain port
//   rd_data_o           selected word
//   count_o, full_o     fill level, full when all three words are held
//   ovf_o               write attempted while full (dropped)
module dtw_sched_result_buf
  import dtw_sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  input  logic        clr_i,
  input  logic [1:0]  rd_idx_i,
  output logic [31:0] rd_data_o,
  output logic [1:0]  count_o,
  output logic        full_o,
  output logic        ovf_o
);

  logic [31:0] mem_q [RESULT_WORDS];
  logic [1:0]  cnt_q;

  assign count_o   = cnt_q;
  assign full_o    = (cnt_q == 2'(RESULT_WORDS));
  assign ovf_o     = wr_en_i && full_o;
  assign rd_data_o = mem_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < RESULT_WORDS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (wr_en_i && !full_o) begin
      mem_q[cnt_q] <= wr_data_i;
      cnt_q        <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/dtw_core_scheduler.sv
// rtl/dtw_core_scheduler.sv - round-robin job dispatcher and result collector for a bank of DTW cores
//
// Purpose: hands each job from the shared source FIFO to one free core,
// captures each core's 3-word result and serialises results to the sink.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   en_i, ref_len_i                 dispatch enable, reference length
//   s_fifo_*                        source FIFO (first-word fall-through)
//   m_fifo_*                        sink FIFO, last marks word 3 of a result
//   core_rs_o, core_busy_i          per-core start pulse / busy
//   core_src_*                      per-core view of the source FIFO
//   core_sink_*                     per-core result write port
//   idle_o, n_dispatched_o, n_completed_o, err_overflow_o   status
module dtw_core_scheduler
  import dtw_sched_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int AXIS_WIDTH = 32,
  parameter int SQG_SIZE   = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [AXIS_WIDTH-1:0] ref_len_i,
  output logic                  s_fifo_rden_o,
  input  logic                  s_fifo_empty_i,
  input  logic [31:0]           s_fifo_data_i,
  output logic                  m_fifo_wren_o,
  input  logic                  m_fifo_full_i,
  output logic [31:0]           m_fifo_data_o,
  output logic                  m_fifo_last_o,
  output logic [N_CORES-1:0]    core_rs_o,
  input  logic [N_CORES-1:0]    core_busy_i,
  input  logic [N_CORES-1:0]    core_src_rden_i,
  output logic [N_CORES-1:0]    core_src_empty_o,
  output logic [31:0]           core_src_data_o,
  input  logic [N_CORES-1:0]    core_sink_wren_i,
  input  logic [32*N_CORES-1:0] core_sink_data_i,
  output logic [N_CORES-1:0]    core_sink_full_o,
  output logic                  idle_o,
  output logic [31:0]           n_dispatched_o,
  output logic [31:0]           n_completed_o,
  output logic                  err_overflow_o
);

  core_state_e          state_q [N_CORES];
  logic                 owner_valid_q;
  logic [2:0]           owner_q;
  logic [JOB_W-1:0]     word_cnt_q, job_words_q;
  logic [2:0]           disp_ptr_q, out_ptr_q, grant_q;
  logic                 grant_valid_q;
  logic [1:0]           out_word_q;
  logic                 out_valid_q, out_last_q, idle_q, err_q;
  logic [31:0]          out_data_q, n_disp_q, n_comp_q;
  logic [N_CORES-1:0]   core_rs_q;

  logic [N_CORES-1:0]   buf_full, buf_ovf, buf_clr, src_empty;
  logic [1:0]           buf_cnt [N_CORES];
  logic [31:0]          buf_rd  [N_CORES];
  logic [MAX_CORES-1:0] free_vec, drain_req;
  logic [3:0]           disp_pick, out_pick;
  logic                 s_rden, accept, last_word, do_disp, load_en, fetch, all_free;
  logic                 sel_valid;
  logic [2:0]           sel_idx;
  logic [1:0]           sel_word;
  logic [31:0]          sel_data;

  assign disp_pick = rr_pick(free_vec, disp_ptr_q, N_CORES);
  assign out_pick  = rr_pick(drain_req, out_ptr_q, N_CORES);
  assign do_disp   = en_i && !owner_valid_q && disp_pick[3];
  assign accept    = s_rden && !s_fifo_empty_i;
  assign last_word = accept && (word_cnt_q + JOB_W'(1) == job_words_q);

  // A held grant keeps feeding the same core; otherwise pick a fresh drainer.
  assign sel_valid = grant_valid_q || out_pick[3];
  assign sel_idx   = grant_valid_q ? grant_q : out_pick[2:0];
  assign sel_word  = grant_valid_q ? out_word_q : 2'd0;

  // The output register refills whenever it is empty or its word is leaving.
  assign m_fifo_wren_o = out_valid_q && !m_fifo_full_i;
  assign load_en       = !out_valid_q || m_fifo_wren_o;
  assign fetch         = load_en && sel_valid;

  always_comb begin
    free_vec  = '0;
    drain_req = '0;
    s_rden    = 1'b0;
    src_empty = '0;
    sel_data  = '0;
    buf_clr   = '0;
    all_free  = 1'b1;
    for (int i = 0; i < N_CORES; i++) begin
      free_vec[i]  = (state_q[i] == CORE_FREE);
      drain_req[i] = (state_q[i] == CORE_DRAIN) && buf_full[i];
      all_free     = all_free && (state_q[i] == CORE_FREE) && (buf_cnt[i] == 2'd0);
      src_empty[i] = s_fifo_empty_i || !(owner_valid_q && owner_q == 3'(i));
      if (owner_valid_q && owner_q == 3'(i)) s_rden = core_src_rden_i[i];
      if (sel_idx == 3'(i)) sel_data = buf_rd[i];
      // Word 3 is copied into the output register, so the buffer can empty now.
      buf_clr[i]   = fetch && (sel_idx == 3'(i)) && (sel_word == 2'd2);
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_buf
    dtw_sched_result_buf u_buf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (core_sink_wren_i[g]),
      .wr_data_i (core_sink_data_i[32*g +: 32]),
      .clr_i     (buf_clr[g]),
      .rd_idx_i  (sel_word),
      .rd_data_o (buf_rd[g]),
      .count_o   (buf_cnt[g]),
      .full_o    (buf_full[g]),
      .ovf_o     (buf_ovf[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CORES; i++) state_q[i] <= CORE_FREE;
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      word_cnt_q    <= '0;
      job_words_q   <= '0;
      disp_ptr_q    <= '0;
      out_ptr_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      out_word_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      core_rs_q     <= '0;
      n_disp_q      <= '0;
      n_comp_q      <= '0;
      err_q         <= 1'b0;
      idle_q        <= 1'b0;
    end else begin
      core_rs_q <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        case (state_q[i])
          CORE_FREE: if (do_disp && disp_pick[2:0] == 3'(i)) begin
            state_q[i]   <= CORE_LOAD;
            core_rs_q[i] <= 1'b1;
          end
          CORE_LOAD:  if (last_word && owner_q == 3'(i)) state_q[i] <= CORE_WAIT;
          CORE_WAIT:  if (buf_full[i]) state_q[i] <= CORE_DRAIN;
          // Drained buffer is not enough: the core must also have gone quiet.
          CORE_DRAIN: if (buf_cnt[i] == 2'd0 && !core_busy_i[i]) state_q[i] <= CORE_FREE;
          default:    state_q[i] <= CORE_FREE;
        endcase
      end

      if (do_disp) begin
        owner_valid_q <= 1'b1;
        owner_q       <= disp_pick[2:0];
        word_cnt_q    <= '0;
        job_words_q   <= JOB_W'(ref_len_i) + JOB_W'(SQG_SIZE + 1);
        disp_ptr_q    <= rr_next(disp_pick[2:0], N_CORES);
        n_disp_q      <= n_disp_q + 32'd1;
      end else if (accept) begin
        word_cnt_q <= word_cnt_q + JOB_W'(1);
        if (last_word) owner_valid_q <= 1'b0;
      end

      if (load_en) begin
        out_valid_q <= sel_valid;
        if (sel_valid) begin
          out_data_q <= sel_data;
          out_last_q <= (sel_word == 2'd2);
          if (sel_word == 2'd2) begin
            grant_valid_q <= 1'b0;
            out_ptr_q     <= rr_next(sel_idx, N_CORES);
          end else begin
            grant_valid_q <= 1'b1;
            grant_q       <= sel_idx;
            out_word_q    <= sel_word + 2'd1;
          end
        end
      end

      if (m_fifo_wren_o && out_last_q) n_comp_q <= n_comp_q + 32'd1;
      if (|buf_ovf) err_q <= 1'b1;
      idle_q <= all_free && !out_valid_q;
    end
  end

  assign s_fifo_rden_o    = s_rden;
  assign core_src_empty_o = src_empty;
  assign core_src_data_o  = s_fifo_data_i;
  assign core_sink_full_o = buf_full;
  assign core_rs_o        = core_rs_q;
  assign m_fifo_data_o    = out_data_q;
  assign m_fifo_last_o    = out_last_q;
  assign idle_o           = idle_q;
  assign n_dispatched_o   = n_disp_q;
  assign n_completed_o    = n_comp_q;
  assign err_overflow_o   = err_q;

endmodule

// File: tb/tb_dtw_core_scheduler.sv
// tb/tb_dtw_core_scheduler.sv - directed self-checking bench for dtw_core_scheduler
module tb_dtw_core_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en;
  logic [31:0]  ref_len;
  logic         s_fifo_rden, s_fifo_empty;
  logic [31:0]  s_fifo_data;
  logic         m_fifo_wren, m_fifo_full, m_fifo_last;
  logic [31:0]  m_fifo_data;
  logic [3:0]   core_rs, core_busy, core_src_rden, core_src_empty, core_sink_wren, core_sink_full;
  logic [31:0]  core_src_data;
  logic [127:0] core_sink_data;
  logic         idle, err_overflow;
  logic [31:0]  n_dispatched, n_completed;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accepted = 0;
  logic [31:0] src_q[$];
  logic [31:0] snk_data[$];
  logic        snk_last[$];
  int          snk_cyc[$];
  logic [3:0]  rs_q[$];

  dtw_core_scheduler #(.N_CORES(4), .AXIS_WIDTH(32), .SQG_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .ref_len_i(ref_len),
    .s_fifo_rden_o(s_fifo_rden), .s_fifo_empty_i(s_fifo_empty), .s_fifo_data_i(s_fifo_data),
    .m_fifo_wren_o(m_fifo_wren), .m_fifo_full_i(m_fifo_full), .m_fifo_data_o(m_fifo_data),
    .m_fifo_last_o(m_fifo_last), .core_rs_o(core_rs), .core_busy_i(core_busy),
    .core_src_rden_i(core_src_rden), .core_src_empty_o(core_src_empty), .core_src_data_o(core_src_data),
    .core_sink_wren_i(core_sink_wren), .core_sink_data_i(core_sink_data), .core_sink_full_o(core_sink_full),
    .idle_o(idle), .n_dispatched_o(n_dispatched), .n_completed_o(n_completed),
    .err_overflow_o(err_overflow)
  );

  task automatic src_refresh();
    s_fifo_empty = (src_q.size() == 0);
    s_fifo_data  = s_fifo_empty ? 32'h0 : src_q[0];
  endtask

  // One clock: observe handshakes mid-cycle, then apply FIFO pops after the edge.
  task automatic step();
    logic pop;
    logic [31:0] dummy;
    @(negedge clk);
    pop = s_fifo_rden && !s_fifo_empty;
    if (m_fifo_wren) begin
      snk_data.push_back(m_fifo_data);
      snk_last.push_back(m_fifo_last);
      snk_cyc.push_back(cyc);
    end
    if (core_rs != 4'b0) rs_q.push_back(core_rs);
    @(posedge clk);
    #1;
    cyc++;
    if (pop) begin
      dummy = src_q.pop_front();
      accepted++;
    end
    src_refresh();
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) src_q.push_back(base + 32'(k));
    src_refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ref_len = 32'd4; m_fifo_full = 1'b0;
    core_busy = '0; core_src_rden = '0; core_sink_wren = '0; core_sink_data = '0;
    src_q.delete(); snk_data.delete(); snk_last.delete(); snk_cyc.delete(); rs_q.delete();
    src_refresh();
    step(); step();
    rst = 1'b0;
    accepted = 0;
  endtask

  task automatic core_result(input int i, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int k = 0; k < 3; k++) begin
      core_sink_wren = 4'(1 << i);
      core_sink_data[32*i +: 32] = w[k];
      step();
    end
    core_sink_wren = '0;
  endtask

  task automatic wait_sink(input int n, input int budget);
    for (int k = 0; k < budget && snk_data.size() < n; k++) step();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    step();
    total++; if (core_rs !== 4'b0) begin bad++; $display("FAIL reset_rs got=%b exp=0000", core_rs); end
    total++; if (core_src_empty !== 4'hF) begin bad++; $display("FAIL reset_src_empty got=%b exp=1111", core_src_empty); end
    total++; if ({s_fifo_rden, m_fifo_wren, m_fifo_last, idle, err_overflow} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {s_fifo_rden, m_fifo_wren, m_fifo_last, idle, err_overflow}); end
    total++; if ({n_dispatched, n_completed, m_fifo_data} !== 96'b0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {n_dispatched, n_completed, m_fifo_data}); end
    rst = 1'b0;
    step();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle_after got=%b exp=1", idle); end
  endtask

  task automatic test_single_job();
    do_reset();
    push_words(32'h100, 16);
    core_src_rden = 4'b0001; core_busy = 4'b0001; en = 1'b1;
    step();
    total++; if (core_rs !== 4'b0001) begin bad++; $display("FAIL single_rs got=%b exp=0001", core_rs); end
    total++; if (core_src_empty !== 4'b1110) begin bad++; $display("FAIL single_route got=%b exp=1110", core_src_empty); end
    en = 1'b0;
    for (int k = 0; k < 30 && accepted < 13; k++) step();
    step(); step(); step();
    total++; if (accepted !== 13) begin bad++; $display("FAIL single_words got=%0d exp=13", accepted); end
    total++; if (core_src_empty[0] !== 1'b1 || s_fifo_rden !== 1'b0) begin bad++; $display("FAIL single_release got=%b/%b exp=1/0", core_src_empty[0], s_fifo_rden); end
    src_q.delete(); src_refresh();
    core_result(0, 32'hA001, 32'h0042, 32'h0007);
    core_busy = '0;
    wait_sink(3, 20);
    total++; if (snk_data.size() !== 3) begin bad++; $display("FAIL single_sink_count got=%0d exp=3", snk_data.size()); end
    else if ({snk_data[0], snk_data[1], snk_data[2]} !== {32'hA001, 32'h0042, 32'h0007} || {snk_last[0], snk_last[1], snk_last[2]} !== 3'b001) begin
      bad++; $display("FAIL single_sink_words got=%h %h %h last=%b%b%b exp=a001 42 7 last=001", snk_data[0], snk_data[1], snk_data[2], snk_last[0], snk_last[1], snk_last[2]);
    end
    total++; if (n_completed !== 32'd1) begin bad++; $display("FAIL single_completed got=%0d exp=1", n_completed); end
    step(); step();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rs [4];
    exp_rs[0] = 4'b0001; exp_rs[1] = 4'b0010; exp_rs[2] = 4'b0100; exp_rs[3] = 4'b1000;
    do_reset();
    push_words(32'h200, 52);
    core_src_rden = 4'hF; core_busy = 4'hF; en = 1'b1;
    for (int k = 0; k < 120 && rs_q.size() < 4; k++) step();
    push_words(32'h300, 13);
    for (int k = 0; k < 4; k++) begin
      total++; if (rs_q.size() <= k || rs_q[k] !== exp_rs[k]) begin bad++; $display("FAIL rr_order_%0d got=%b exp=%b", k, (rs_q.size() > k) ? rs_q[k] : 4'b0, exp_rs[k]); end
    end
    for (int k = 0; k < 30; k++) step();
    total++; if (rs_q.size() !== 4 || n_dispatched !== 32'd4) begin bad++; $display("FAIL rr_fifth_waits got=%0d/%0d exp=4/4", rs_q.size(), n_dispatched); end
    total++; if (accepted !== 52) begin bad++; $display("FAIL rr_words got=%0d exp=52", accepted); end
    core_result(2, 32'hC2, 32'h12, 32'h3);
    core_busy = 4'b1011;
    for (int k = 0; k < 30 && rs_q.size() < 5; k++) step();
    total++; if (rs_q.size() != 5 || rs_q[4] !== 4'b0100) begin bad++; $display("FAIL rr_fifth_core got=%b exp=0100", (rs_q.size() > 4) ? rs_q[4] : 4'b0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [6];
    logic        exp_l [6];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
    exp_d[3] = 32'hB0; exp_d[4] = 32'hB1; exp_d[5] = 32'hB2;
    for (int k = 0; k < 6; k++) exp_l[k] = (k == 2 || k == 5);
    do_reset();
    m_fifo_full = 1'b1;
    push_words(32'h400, 26);
    core_src_rden = 4'hF; core_busy = 4'b0011; en = 1'b1;
    for (int k = 0; k < 60 && accepted < 26; k++) begin
      step();
      if (rs_q.size() >= 2) en = 1'b0;
    end
    total++; if (rs_q.size() !== 2 || accepted !== 26) begin bad++; $display("FAIL bp_setup got=%0d/%0d exp=2/26", rs_q.size(), accepted); end
    for (int k = 0; k < 3; k++) begin
      core_sink_wren = 4'b0011;
      core_sink_data[31:0]  = exp_d[k];
      core_sink_data[63:32] = exp_d[k+3];
      step();
    end
    core_sink_wren = '0; core_busy = '0;
    for (int k = 0; k < 10; k++) step();
    total++; if (snk_data.size() !== 0 || m_fifo_wren !== 1'b0) begin bad++; $display("FAIL bp_hold got=%0d/%b exp=0/0", snk_data.size(), m_fifo_wren); end
    m_fifo_full = 1'b0;
    wait_sink(6, 20);
    for (int k = 0; k < 6; k++) begin
      total++; if (snk_data.size() <= k || snk_data[k] !== exp_d[k] || snk_last[k] !== exp_l[k]) begin
        bad++; $display("FAIL bp_word_%0d got=%h exp=%h last_exp=%b", k, (snk_data.size() > k) ? snk_data[k] : 32'h0, exp_d[k], exp_l[k]);
      end
    end
    total++; if (snk_cyc.size() != 6 || snk_cyc[5] - snk_cyc[0] !== 5) begin bad++; $display("FAIL bp_contiguous got=%0d exp=5", (snk_cyc.size() == 6) ? snk_cyc[5] - snk_cyc[0] : -1); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_d [6];
    exp_d[0] = 32'hC0; exp_d[1] = 32'hC1; exp_d[2] = 32'hC2;
    exp_d[3] = 32'hD0; exp_d[4] = 32'hD1; exp_d[5] = 32'hD2;
    do_reset();
    m_fifo_full = 1'b1;
    push_words(32'h500, 26);
    core_src_rden = 4'b0001; core_busy = 4'b0011; en = 1'b1;
    for (int k = 0; k < 60 && rs_q.size() < 2; k++) step();
    en = 1'b0;
    total++; if (accepted !== 13 || rs_q.size() !== 2) begin bad++; $display("FAIL sim_setup got=%0d/%0d exp=13/2", accepted, rs_q.size()); end
    core_result(0, exp_d[0], exp_d[1], exp_d[2]);
    core_busy = 4'b0010;
    core_src_rden = 4'b0010;
    for (int k = 0; k < 30 && accepted < 25; k++) step();
    core_src_rden = '0;
    m_fifo_full = 1'b0;
    step();
    core_src_rden = 4'b0010;
    step();
    core_src_rden = '0;
    total++; if (accepted !== 26 || snk_data.size() !== 2) begin bad++; $display("FAIL sim_same_cycle got=%0d/%0d exp=26/2", accepted, snk_data.size()); end
    step(); step();
    total++; if (core_src_empty[1] !== 1'b1 || s_fifo_rden !== 1'b0) begin bad++; $display("FAIL sim_release got=%b/%b exp=1/0", core_src_empty[1], s_fifo_rden); end
    core_result(1, exp_d[3], exp_d[4], exp_d[5]);
    core_busy = '0;
    wait_sink(6, 20);
    for (int k = 0; k < 6; k++) begin
      total++; if (snk_data.size() != 6 || snk_data[k] !== exp_d[k] || snk_last[k] !== (k == 2 || k == 5)) begin
        bad++; $display("FAIL sim_word_%0d got=%h exp=%h count=%0d", k, (snk_data.size() > k) ? snk_data[k] : 32'h0, exp_d[k], snk_data.size());
      end
    end
    total++; if (n_completed !== 32'd2 || n_dispatched !== 32'd2) begin bad++; $display("FAIL sim_counters got=%0d/%0d exp=2/2", n_completed, n_dispatched); end
  endtask

  task automatic test_overflow();
    logic [31:0] w [4];
    w[0] = 32'hE0; w[1] = 32'hE1; w[2] = 32'hE2; w[3] = 32'hE3;
    do_reset();
    m_fifo_full = 1'b1;
    push_words(32'h600, 13);
    core_src_rden = 4'b0001; core_busy = 4'b0001; en = 1'b1;
    for (int k = 0; k < 40 && accepted < 13; k++) begin
      step();
      if (rs_q.size() >= 1) en = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      core_sink_wren = 4'b0001;
      core_sink_data[31:0] = w[k];
      step();
      if (k == 2) begin
        total++; if (core_sink_full !== 4'b0001 || err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b/%b exp=0001/0", core_sink_full, err_overflow); end
      end
    end
    core_sink_wren = '0; core_busy = '0;
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", err_overflow); end
    for (int k = 0; k < 5; k++) step();
    m_fifo_full = 1'b0;
    wait_sink(3, 20);
    for (int k = 0; k < 3; k++) begin
      total++; if (snk_data.size() != 3 || snk_data[k] !== w[k]) begin bad++; $display("FAIL ovf_word_%0d got=%h exp=%h", k, (snk_data.size() > k) ? snk_data[k] : 32'h0, w[k]); end
    end
    for (int k = 0; k < 5; k++) step();
    total++; if (err_overflow !== 1'b1 || snk_data.size() !== 3) begin bad++; $display("FAIL ovf_sticky got=%b/%0d exp=1/3", err_overflow, snk_data.size()); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    push_words(32'h700, 13);
    core_src_rden = 4'b0001; core_busy = 4'b0001; en = 1'b1;
    for (int k = 0; k < 30 && accepted < 5; k++) step();
    total++; if (accepted !== 5) begin bad++; $display("FAIL midrst_progress got=%0d exp=5", accepted); end
    rst = 1'b1; en = 1'b0;
    step();
    total++; if (core_rs !== 4'b0 || core_src_empty !== 4'hF || s_fifo_rden !== 1'b0) begin bad++; $display("FAIL midrst_src got=%b/%b/%b exp=0000/1111/0", core_rs, core_src_empty, s_fifo_rden); end
    total++; if ({m_fifo_wren, idle, err_overflow} !== 3'b0 || n_dispatched !== 32'd0) begin bad++; $display("FAIL midrst_status got=%b/%0d exp=000/0", {m_fifo_wren, idle, err_overflow}, n_dispatched); end
    rst = 1'b0;
    step();
    total++; if (idle !== 1'b1 || snk_data.size() !== 0) begin bad++; $display("FAIL midrst_idle got=%b/%0d exp=1/0", idle, snk_data.size()); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
